// File: rtl/esc_pkg.sv
// Shared types and constants for the C-PHY escape-mode command decoder.
// Command values are the LSB-first byte as delivered by the deserializer.
package esc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_LPDT,
        ST_ULPS,
        ST_TRIG,
        ST_ERR
    } esc_state_e;

    localparam logic [7:0] CMD_LPDT     = 8'h87;
    localparam logic [7:0] CMD_ULPS     = 8'h78;
    localparam logic [7:0] CMD_RST_TRIG = 8'h46;
    localparam logic [7:0] CMD_TRIG1    = 8'hBA;
    localparam logic [7:0] CMD_TRIG2    = 8'h84;
    localparam logic [7:0] CMD_TRIG3    = 8'h05;

    localparam int TRIG_RST_IDX = 0;
    localparam int TRIG1_IDX    = 1;
    localparam int TRIG2_IDX    = 2;
    localparam int TRIG3_IDX    = 3;

    // Zero when the byte is not one of the trigger commands.
    function automatic logic [3:0] trig_onehot(input logic [7:0] cmd);
        trig_onehot = '0;
        case (cmd)
            CMD_RST_TRIG: trig_onehot[TRIG_RST_IDX] = 1'b1;
            CMD_TRIG1:    trig_onehot[TRIG1_IDX]    = 1'b1;
            CMD_TRIG2:    trig_onehot[TRIG2_IDX]    = 1'b1;
            CMD_TRIG3:    trig_onehot[TRIG3_IDX]    = 1'b1;
            default:      trig_onehot = '0;
        endcase
    endfunction

endpackage

// File: rtl/esc_cmd_decoder.sv
// Escape-mode command decoder: decodes the entry command byte and drives
// LPDT data, ULPS, trigger and error indications. Falling-edge RxClkEsc domain.
module esc_cmd_decoder
    import esc_pkg::*;
#(
    parameter int CMD_TIMEOUT = 16
) (
    input  logic       RxClkEsc,
    input  logic       RstN,
    input  logic       EscEntry,
    input  logic       StopDetect,
    input  logic       RxValidEsc,
    input  logic [7:0] RxEscData,
    output logic       EscDeserEn,
    output logic       RxLpdtEsc,
    output logic       RxUlpsEsc,
    output logic [3:0] RxTriggerEsc,
    output logic [7:0] RxDataEsc,
    output logic       RxValidDataEsc,
    output logic       ErrEsc,
    output logic       ErrSyncEsc
);

    localparam int TW = $clog2(CMD_TIMEOUT) + 1;

    esc_state_e    state_q;
    logic [TW-1:0] tmo_q;
    logic [2:0]    phase_q;
    logic          deser_en_q, lpdt_q, ulps_q, vdata_q, err_q, err_sync_q;
    logic [3:0]    trig_q;
    logic [7:0]    data_q;

    logic       byte_acc;
    logic [3:0] trig_dec;

    // The deserializer strobe only counts while we have it enabled.
    assign byte_acc = RxValidEsc && deser_en_q;
    assign trig_dec = trig_onehot(RxEscData);

    always_ff @(negedge RxClkEsc or negedge RstN) begin
        if (!RstN) begin
            state_q    <= ST_IDLE;
            tmo_q      <= '0;
            phase_q    <= '0;
            deser_en_q <= 1'b0;
            lpdt_q     <= 1'b0;
            ulps_q     <= 1'b0;
            trig_q     <= '0;
            data_q     <= '0;
            vdata_q    <= 1'b0;
            err_q      <= 1'b0;
            err_sync_q <= 1'b0;
        end else begin
            vdata_q    <= 1'b0;
            err_q      <= 1'b0;
            err_sync_q <= 1'b0;
            trig_q     <= '0;
            if (state_q != ST_IDLE && StopDetect) begin
                state_q    <= ST_IDLE;
                deser_en_q <= 1'b0;
                lpdt_q     <= 1'b0;
                ulps_q     <= 1'b0;
                if (state_q == ST_LPDT && phase_q != 3'd0)
                    err_sync_q <= 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (EscEntry && !StopDetect) begin
                            state_q    <= ST_CMD;
                            deser_en_q <= 1'b1;
                            tmo_q      <= '0;
                        end
                    end
                    ST_CMD: begin
                        if (byte_acc) begin
                            if (RxEscData == CMD_LPDT) begin
                                state_q <= ST_LPDT;
                                lpdt_q  <= 1'b1;
                                phase_q <= '0;
                            end else if (RxEscData == CMD_ULPS) begin
                                state_q    <= ST_ULPS;
                                ulps_q     <= 1'b1;
                                deser_en_q <= 1'b0;
                            end else if (trig_dec != 4'd0) begin
                                state_q    <= ST_TRIG;
                                trig_q     <= trig_dec;
                                deser_en_q <= 1'b0;
                            end else begin
                                state_q    <= ST_ERR;
                                err_q      <= 1'b1;
                                deser_en_q <= 1'b0;
                            end
                        end else if (tmo_q == TW'(CMD_TIMEOUT - 1)) begin
                            state_q    <= ST_ERR;
                            err_q      <= 1'b1;
                            deser_en_q <= 1'b0;
                        end else begin
                            tmo_q <= tmo_q + 1'b1;
                        end
                    end
                    ST_LPDT: begin
                        // phase_q tracks edges since the last byte boundary.
                        if (byte_acc) begin
                            data_q  <= RxEscData;
                            vdata_q <= 1'b1;
                            phase_q <= '0;
                        end else begin
                            phase_q <= phase_q + 3'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign EscDeserEn     = deser_en_q;
    assign RxLpdtEsc      = lpdt_q;
    assign RxUlpsEsc      = ulps_q;
    assign RxTriggerEsc   = trig_q;
    assign RxDataEsc      = data_q;
    assign RxValidDataEsc = vdata_q;
    assign ErrEsc         = err_q;
    assign ErrSyncEsc     = err_sync_q;

endmodule

// File: tb/tb_esc_cmd_decoder.sv
// Self-checking bench for esc_cmd_decoder: LPDT payload via scoreboard queue,
// direct checks for ULPS, triggers, errors, priority and reset.
module tb_esc_cmd_decoder;

    logic       RxClkEsc = 1'b1;
    logic       RstN = 1'b0;
    logic       EscEntry = 1'b0;
    logic       StopDetect = 1'b0;
    logic       RxValidEsc = 1'b0;
    logic [7:0] RxEscData = 8'h00;
    logic       EscDeserEn, RxLpdtEsc, RxUlpsEsc, RxValidDataEsc, ErrEsc, ErrSyncEsc;
    logic [3:0] RxTriggerEsc;
    logic [7:0] RxDataEsc;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] sb_q[$];

    esc_cmd_decoder #(.CMD_TIMEOUT(16)) dut (
        .RxClkEsc(RxClkEsc), .RstN(RstN), .EscEntry(EscEntry),
        .StopDetect(StopDetect), .RxValidEsc(RxValidEsc), .RxEscData(RxEscData),
        .EscDeserEn(EscDeserEn), .RxLpdtEsc(RxLpdtEsc), .RxUlpsEsc(RxUlpsEsc),
        .RxTriggerEsc(RxTriggerEsc), .RxDataEsc(RxDataEsc),
        .RxValidDataEsc(RxValidDataEsc), .ErrEsc(ErrEsc), .ErrSyncEsc(ErrSyncEsc)
    );

    always #5 RxClkEsc = ~RxClkEsc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [17:0] all_outs();
        return {EscDeserEn, RxLpdtEsc, RxUlpsEsc, RxTriggerEsc, RxDataEsc,
                RxValidDataEsc, ErrEsc, ErrSyncEsc};
    endfunction

    // Inputs change 1 ns after the rising edge; the DUT samples on the falling edge.
    task automatic cyc();
        @(posedge RxClkEsc);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        RxEscData  = b;
        RxValidEsc = 1'b1;
        cyc();
        RxValidEsc = 1'b0;
    endtask

    task automatic entry();
        EscEntry = 1'b1;
        cyc();
        EscEntry = 1'b0;
        chk("entry_en", EscDeserEn, 1);
    endtask

    task automatic stop();
        StopDetect = 1'b1;
        cyc();
        StopDetect = 1'b0;
    endtask

    // Payload monitor: every strobe must match the oldest expected byte.
    always @(posedge RxClkEsc) begin
        if (RstN && RxValidDataEsc === 1'b1) begin
            if (sb_q.size() == 0) chk("vd_unexpected", 1, 0);
            else chk("vd_data", RxDataEsc, sb_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] trig_cmd [4];
        logic [3:0] trig_exp [4];
        trig_cmd = '{8'h46, 8'hBA, 8'h84, 8'h05};
        trig_exp = '{4'h1, 4'h2, 4'h4, 4'h8};

        cyc(); cyc();
        chk("reset_outs", all_outs(), 0);
        RstN = 1'b1;
        cyc();
        chk("post_reset_outs", all_outs(), 0);

        // LPDT, aligned stop
        entry();
        send_byte(8'h87);
        chk("lpdt_on", RxLpdtEsc, 1);
        sb_q.push_back(8'hA5);
        send_byte(8'hA5);
        chk("vd_lat_a5", RxValidDataEsc, 1);
        sb_q.push_back(8'h3C);
        send_byte(8'h3C);
        chk("vd_lat_3c", RxValidDataEsc, 1);
        stop();
        chk("lpdt_stop_en", EscDeserEn, 0);
        chk("lpdt_stop_lpdt", RxLpdtEsc, 0);
        chk("lpdt_aligned_sync", ErrSyncEsc, 0);
        chk("lpdt_data_hold", RxDataEsc, 8'h3C);

        // ULPS with stray valid
        entry();
        send_byte(8'h78);
        chk("ulps_on", RxUlpsEsc, 1);
        chk("ulps_en", EscDeserEn, 0);
        RxEscData = 8'h87; RxValidEsc = 1'b1;
        repeat (3) cyc();
        RxValidEsc = 1'b0;
        chk("ulps_stray_lpdt", RxLpdtEsc, 0);
        repeat (17) cyc();
        chk("ulps_hold", RxUlpsEsc, 1);
        stop();
        chk("ulps_off", RxUlpsEsc, 0);
        chk("ulps_exit_en", EscDeserEn, 0);

        // Triggers
        for (int i = 0; i < 4; i++) begin
            entry();
            send_byte(trig_cmd[i]);
            chk($sformatf("trig%0d_val", i), RxTriggerEsc, trig_exp[i]);
            chk($sformatf("trig%0d_lpdt", i), RxLpdtEsc, 0);
            chk($sformatf("trig%0d_en", i), EscDeserEn, 0);
            cyc();
            chk($sformatf("trig%0d_clear", i), RxTriggerEsc, 0);
            stop();
        end

        // Bad command
        entry();
        send_byte(8'hFF);
        chk("badcmd_err", ErrEsc, 1);
        chk("badcmd_en", EscDeserEn, 0);
        cyc();
        chk("badcmd_err_clear", ErrEsc, 0);
        stop();

        // Command timeout: ErrEsc on the 16th edge after entry
        entry();
        repeat (15) cyc();
        chk("tmo_early", ErrEsc, 0);
        cyc();
        chk("tmo_err", ErrEsc, 1);
        chk("tmo_en", EscDeserEn, 0);
        stop();

        // Sync error: stop three edges after the last byte
        entry();
        send_byte(8'h87);
        sb_q.push_back(8'h11);
        send_byte(8'h11);
        cyc(); cyc();
        stop();
        chk("sync_err", ErrSyncEsc, 1);
        cyc();
        chk("sync_err_clear", ErrSyncEsc, 0);

        // Stop coincident with a byte drops it
        entry();
        send_byte(8'h87);
        StopDetect = 1'b1; RxEscData = 8'h55; RxValidEsc = 1'b1;
        cyc();
        StopDetect = 1'b0; RxValidEsc = 1'b0;
        chk("prio_no_vd", RxValidDataEsc, 0);
        chk("prio_lpdt_off", RxLpdtEsc, 0);

        // Stop with entry in IDLE stays IDLE
        StopDetect = 1'b1; EscEntry = 1'b1;
        cyc();
        StopDetect = 1'b0; EscEntry = 1'b0;
        chk("idle_stop_entry", EscDeserEn, 0);

        // Asynchronous reset mid-LPDT
        entry();
        send_byte(8'h87);
        sb_q.push_back(8'hC3);
        send_byte(8'hC3);
        RstN = 1'b0;
        #1;
        chk("async_rst_outs", all_outs(), 0);
        cyc(); cyc();
        RstN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk($sformatf("rst_release_%0d", i), all_outs(), 0);
        end
        entry();
        send_byte(8'h87);
        chk("rst_relpdt", RxLpdtEsc, 1);
        sb_q.push_back(8'h5A);
        send_byte(8'h5A);
        stop();
        cyc();

        chk("sb_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/esc_cmd_decoder.md
Name: esc_cmd_decoder

Overview:
Escape-mode command decoder for the C-PHY receiver lane. It sits directly downstream of the escape deserializer and runs in the same falling-edge RxClkEsc domain. It owns the deserializer enable, decodes the first received byte as the escape entry command, and then does one of three things: forwards LPDT payload bytes, holds the ULPS indication, or pulses a trigger. It also reports command errors and partial-byte (sync) errors to the PPI.

Parameters:
CMD_TIMEOUT, 16, number of RxClkEsc falling edges allowed in CMD state before the command byte must arrive; on expiry, ErrEsc.

Ports:
RxClkEsc  in  1  escape clock; all flops update on the falling edge
RstN  in  1  reset, asynchronous, active-low
EscEntry  in  1  one-cycle pulse from the LP sequence detector when the escape entry sequence completes
StopDetect  in  1  LP-111 stop state seen; exits escape mode
RxValidEsc  in  1  byte-valid pulse from the deserializer
RxEscData  in  8  deserialized byte, LSB first on the wire
EscDeserEn  out  1  enable to the deserializer
RxLpdtEsc  out  1  high while in LPDT
RxUlpsEsc  out  1  high while in ULPS
RxTriggerEsc  out  4  one-hot trigger pulse: [0] reset, [1..3] trigger 1..3
RxDataEsc  out  8  LPDT payload byte
RxValidDataEsc  out  1  one-cycle strobe for RxDataEsc
ErrEsc  out  1  one-cycle pulse: unrecognised command or timeout
ErrSyncEsc  out  1  one-cycle pulse: stop seen mid-byte during LPDT

Behaviour:
- Reset values: all outputs 0, state IDLE, cycle counters 0.
- States: IDLE, CMD, LPDT, ULPS, TRIG, ERR. All outputs are registered.
- A byte is accepted only when RxValidEsc=1 and the registered EscDeserEn=1. While EscDeserEn=0, RxValidEsc is ignored, including when it is held high.
- IDLE:
  - EscEntry=1 -> go to CMD; set EscDeserEn=1; clear the timeout counter.
  - EscEntry is ignored in every other state.
- CMD (command byte valid at edge N; state and outputs update at edge N+1):
  - 8'h87 -> LPDT; RxLpdtEsc=1.
  - 8'h78 -> ULPS; RxUlpsEsc=1; EscDeserEn=0.
  - 8'h46 / 8'hBA / 8'h84 / 8'h05 -> TRIG; RxTriggerEsc = 4'b0001 / 0010 / 0100 / 1000 respectively for one cycle; EscDeserEn=0.
  - Any other value -> ERR; ErrEsc pulses one cycle; EscDeserEn=0.
  - Timeout counter reaches CMD_TIMEOUT with no byte -> ERR with an ErrEsc pulse.
- LPDT:
  - Each accepted byte -> RxDataEsc <= RxEscData and RxValidDataEsc=1 for exactly one cycle (latency 1 edge). RxDataEsc holds its value between strobes.
  - A 3-bit bit-phase counter resets to 0 on entry and on each accepted byte, and increments every edge otherwise. It mirrors the deserializer's bit position.
- Exit: StopDetect=1 in CMD, LPDT, ULPS, TRIG or ERR -> IDLE at the next edge.
  - Clears EscDeserEn, RxLpdtEsc and RxUlpsEsc.
  - If the state was LPDT and the bit-phase counter is not 0 (counter counts edges since last byte; 0 = aligned), pulse ErrSyncEsc.
- Simultaneous events:
  - StopDetect has priority over RxValidEsc in the same cycle; that byte is dropped and no RxValidDataEsc is issued.
  - StopDetect with EscEntry in IDLE -> stay in IDLE.
- TRIG and ERR wait for StopDetect. Any bytes are ignored because EscDeserEn=0.
- ULPS: RxUlpsEsc stays high until StopDetect. The deserializer stays disabled.
- Reset mid-operation: everything returns to reset values immediately (asynchronous). No pulse outputs fire on reset release.

Decomposition:
- Shared package esc_pkg holds:
  - the state enum;
  - command constants CMD_LPDT=8'h87, CMD_ULPS=8'h78, CMD_RST_TRIG=8'h46, CMD_TRIG1=8'hBA, CMD_TRIG2=8'h84, CMD_TRIG3=8'h05 (wire order already folded into LSB-first byte values);
  - trigger one-hot indices.
- The block is a single module. A sub-module is not warranted, because the command compare is a small combinational case inside the FSM.

Test Plan:
- LPDT path: EscEntry pulse, then byte 8'h87, then bytes 8'hA5 and 8'h3C, then StopDetect aligned.
  - Expect RxLpdtEsc=1 one edge after the command.
  - Expect two RxValidDataEsc strobes carrying A5 then 3C, each one edge after its RxValidEsc.
  - Expect EscDeserEn to drop after stop, with ErrSyncEsc=0.
- ULPS: entry, then 8'h78.
  - Expect RxUlpsEsc=1 and EscDeserEn=0.
  - Expect a stray RxValidEsc=1 to be ignored.
  - StopDetect 20 edges later -> RxUlpsEsc=0 and state IDLE.
- Triggers: the four trigger bytes in separate entries (46/BA/84/05) -> RxTriggerEsc = 1/2/4/8, each high exactly one cycle, with no RxLpdtEsc.
- Errors:
  - Command 8'hFF -> ErrEsc one-cycle pulse, EscDeserEn=0, then IDLE on stop.
  - Entry with no byte for 16 edges -> ErrEsc pulse.
- Sync error and priority:
  - In LPDT, StopDetect 3 edges after the last byte -> ErrSyncEsc pulse.
  - StopDetect coincident with RxValidEsc -> no RxValidDataEsc.
- Reset: assert RstN=0 mid-LPDT -> all outputs 0 immediately; after release, no pulses fire and the next EscEntry decodes normally.
